// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - fetch unit: single-outstanding imem requests, output register plus skid entry, redirect flush.
module instruction_fetch #(
  parameter int                   DataWidth   = 32,
  parameter logic [DataWidth-1:0] ResetVector = '0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  output logic                 imem_req_valid,
  input  logic                 imem_req_ready,
  output logic [DataWidth-1:0] imem_addr,
  input  logic                 imem_rsp_valid,
  input  logic [DataWidth-1:0] imem_rsp_data,
  input  logic                 redirect_valid,
  input  logic [DataWidth-1:0] redirect_target,
  output logic                 if_valid,
  input  logic                 if_ready,
  output logic [DataWidth-1:0] if_instruction,
  output logic [DataWidth-1:0] if_pc,
  output logic [DataWidth-1:0] if_pc_plus4
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_FLUSH} state_t;

  localparam logic [DataWidth-1:0] AlignMask = ~DataWidth'(3);
  localparam logic [DataWidth-1:0] Four      = DataWidth'(4);

  state_t               state;
  logic [DataWidth-1:0] fetch_pc;
  logic [DataWidth-1:0] req_pc;
  logic                 skid_valid;
  logic [DataWidth-1:0] skid_instr;
  logic [DataWidth-1:0] skid_pc;

  logic handshake;
  logic consume;
  logic rsp_take;

  // fetch_pc is kept word-aligned, so it drives the address directly
  assign imem_addr      = fetch_pc;
  assign imem_req_valid = rst_n && (state == S_REQ) && !skid_valid;
  assign handshake      = imem_req_valid && imem_req_ready;
  assign consume        = if_valid && if_ready;
  assign rsp_take       = (state == S_WAIT) && imem_rsp_valid;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= S_REQ;
      fetch_pc       <= ResetVector & AlignMask;
      req_pc         <= '0;
      if_valid       <= 1'b0;
      if_instruction <= '0;
      if_pc          <= '0;
      if_pc_plus4    <= '0;
      skid_valid     <= 1'b0;
      skid_instr     <= '0;
      skid_pc        <= '0;
    end else if (redirect_valid) begin
      if_valid   <= 1'b0;
      skid_valid <= 1'b0;
      fetch_pc   <= redirect_target & AlignMask;
      // any request still in flight must be swallowed before refetching
      case (state)
        S_REQ:   state <= handshake ? S_FLUSH : S_REQ;
        default: state <= imem_rsp_valid ? S_REQ : S_FLUSH;
      endcase
    end else begin
      case (state)
        S_REQ: begin
          if (handshake) begin
            state    <= S_WAIT;
            req_pc   <= fetch_pc;
            fetch_pc <= fetch_pc + Four;
          end
        end
        default: begin
          if (imem_rsp_valid) state <= S_REQ;
        end
      endcase

      // skid full implies no request outstanding, so these cases never overlap
      if (consume && skid_valid) begin
        if_instruction <= skid_instr;
        if_pc          <= skid_pc;
        if_pc_plus4    <= skid_pc + Four;
        skid_valid     <= 1'b0;
      end else if (rsp_take && (!if_valid || consume)) begin
        if_valid       <= 1'b1;
        if_instruction <= imem_rsp_data;
        if_pc          <= req_pc;
        if_pc_plus4    <= req_pc + Four;
      end else if (rsp_take) begin
        skid_valid <= 1'b1;
        skid_instr <= imem_rsp_data;
        skid_pc    <= req_pc;
      end else if (consume) begin
        if_valid <= 1'b0;
      end
    end
  end

endmodule
